hpdcache_sram_wmask_banked: RTL and testbench

Parametrised multi-bank 1RW SRAM wrapper with per-bit write mask, for HPDcache data/tag arrays needing several independent banks. Adds features the single-bank wrapper lacks: a hardware zero-initialisation sweep after reset or on request, an optional output pipeline register, and read-data hold. Sits between the cache datapath controllers and the per-bank storage.

---
 rtl/hpdcache_sram_wmask_banked.sv | 132 +++++++++++++
 tb/tb_hpdcache_sram_wmask_banked.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_sram_wmask_banked.sv
// Multi-bank 1RW SRAM with per-bit write mask, zero-init sweep, optional output register
// and read-data hold. Each bank has its own address/data slice of the flat ports.
module hpdcache_sram_wmask_banked #(
  parameter int unsigned ADDR_SIZE     = 6,
  parameter int unsigned DATA_SIZE     = 64,
  parameter int unsigned DEPTH         = 2**ADDR_SIZE,
  parameter int unsigned NBANKS        = 4,
  parameter int unsigned OUT_REG       = 0,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_req,
  output logic                          ready,
  input  logic [NBANKS-1:0]             cs,
  input  logic [NBANKS-1:0]             we,
  input  logic [NBANKS*ADDR_SIZE-1:0]   addr,
  input  logic [NBANKS*DATA_SIZE-1:0]   wdata,
  input  logic [NBANKS*DATA_SIZE-1:0]   wmask,
  output logic [NBANKS*DATA_SIZE-1:0]   rdata,
  output logic [NBANKS-1:0]             rvalid
);

  typedef enum logic {ST_IDLE, ST_INIT} state_t;

  localparam state_t              RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(DEPTH);

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR_SIZE-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready        = (r_state == ST_IDLE);
    case (r_state)
      ST_IDLE: if (init_req) w_state_next = ST_INIT;
      ST_INIT: if (r_cnt == LAST_ADDR) w_state_next = ST_IDLE;
      default: w_state_next = RST_STATE;
    endcase
  end

  // Counter is held at zero while idle so every sweep starts from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_bank
      logic [DATA_SIZE-1:0] r_mem [DEPTH];
      logic [DATA_SIZE-1:0] r_rd_data;
      logic                 r_rd_valid;
      logic [ADDR_SIZE-1:0] w_addr;
      logic [DATA_SIZE-1:0] w_wdata;
      logic [DATA_SIZE-1:0] w_wmask;
      logic                 w_in_range;
      logic                 w_user;
      logic                 w_rd;

      assign w_addr     = addr[gi*ADDR_SIZE +: ADDR_SIZE];
      assign w_wdata    = wdata[gi*DATA_SIZE +: DATA_SIZE];
      assign w_wmask    = wmask[gi*DATA_SIZE +: DATA_SIZE];
      assign w_in_range = ({1'b0, w_addr} < DEPTH_EXT);
      assign w_user     = (r_state == ST_IDLE) && cs[gi];
      assign w_rd       = w_user && !we[gi];

      // Storage has no reset; writes are suppressed while rst is held so reset never alters contents.
      always_ff @(posedge clk) begin
        if (!rst) begin
          if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
          end else if (w_user && we[gi] && w_in_range) begin
            r_mem[w_addr] <= (r_mem[w_addr] & ~w_wmask) | (w_wdata & w_wmask);
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd;
          if (w_rd) begin
            r_rd_data <= w_in_range ? r_mem[w_addr] : '0;
          end
        end
      end

      if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_SIZE-1:0] r_out_data;
        logic                 r_out_valid;

        // Second stage is not gated by the FSM, so a read already in flight survives a sweep start.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid <= r_rd_valid;
            if (r_rd_valid) begin
              r_out_data <= r_rd_data;
            end
          end
        end

        assign rdata[gi*DATA_SIZE +: DATA_SIZE] = r_out_data;
        assign rvalid[gi]                       = r_out_valid;
      end else begin : g_no_out_reg
        assign rdata[gi*DATA_SIZE +: DATA_SIZE] = r_rd_data;
        assign rvalid[gi]                       = r_rd_valid;
      end
    end
  endgenerate

endmodule

// File: tb/tb_hpdcache_sram_wmask_banked.sv
// Bench for the banked masked SRAM: one default instance (latency 1, init on reset) and one
// with DEPTH=48, output register and no automatic init. Reads are scored through per-bank queues.
`timescale 1ns/1ps
module tb_hpdcache_sram_wmask_banked;
  localparam int AW = 6;
  localparam int DW = 64;
  localparam int NB = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              init_req, ready;
  logic [NB-1:0]     cs, we, rvalid;
  logic [NB*AW-1:0]  addr;
  logic [NB*DW-1:0]  wdata, wmask, rdata;

  logic              init_b, ready_b;
  logic [NB-1:0]     cs_b, we_b, rvalid_b;
  logic [NB*AW-1:0]  addr_b;
  logic [NB*DW-1:0]  wdata_b, wmask_b, rdata_b;

  hpdcache_sram_wmask_banked dut (
    .clk(clk), .rst(rst), .init_req(init_req), .ready(ready),
    .cs(cs), .we(we), .addr(addr), .wdata(wdata), .wmask(wmask),
    .rdata(rdata), .rvalid(rvalid)
  );

  hpdcache_sram_wmask_banked #(.DEPTH(48), .OUT_REG(1), .INIT_ON_RESET(0)) dut48 (
    .clk(clk), .rst(rst), .init_req(init_b), .ready(ready_b),
    .cs(cs_b), .we(we_b), .addr(addr_b), .wdata(wdata_b), .wmask(wmask_b),
    .rdata(rdata_b), .rvalid(rvalid_b)
  );

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    int          bank;
    bit          w;
    int          a;
    logic [63:0] d;
    logic [63:0] m;
    logic [63:0] exp;
  } vec_t;

  exp_t sb_q [8][$];
  vec_t tab [11];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ports 0..3 are the default instance, 4..7 the DEPTH=48 instance.
  always @(negedge clk) begin : mon
    logic        v;
    logic [63:0] d;
    exp_t        e;
    for (int p = 0; p < 8; p++) begin
      v = (p < 4) ? rvalid[p] : rvalid_b[p-4];
      d = (p < 4) ? rdata[p*DW +: DW] : rdata_b[(p-4)*DW +: DW];
      if (sb_q[p].size() > 0 && sb_q[p][0].cyc <= cyc) begin
        e = sb_q[p].pop_front();
        check($sformatf("rvalid_p%0d", p), {63'b0, v}, 64'd1);
        if (v) check($sformatf("rdata_p%0d", p), d, e.data);
        $display("read p%0d: rvalid=%0b rdata=%h expected %h", p, v, d, e.data);
      end else if (v) begin
        check($sformatf("spurious_rvalid_p%0d", p), {63'b0, v}, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    cs = '0; we = '0; addr = '0; wdata = '0; wmask = '0; init_req = 1'b0;
  endtask

  task automatic idle_b();
    cs_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; wmask_b = '0; init_b = 1'b0;
  endtask

  task automatic op(input int b, input bit w, input int a, input logic [63:0] d, input logic [63:0] m);
    cs[b] = 1'b1;
    we[b] = w;
    addr[b*AW +: AW]  = AW'(a);
    wdata[b*DW +: DW] = d;
    wmask[b*DW +: DW] = m;
  endtask

  task automatic op_b(input int b, input bit w, input int a, input logic [63:0] d, input logic [63:0] m);
    cs_b[b] = 1'b1;
    we_b[b] = w;
    addr_b[b*AW +: AW]  = AW'(a);
    wdata_b[b*DW +: DW] = d;
    wmask_b[b*DW +: DW] = m;
  endtask

  task automatic expect_rd(input int p, input int lat, input logic [63:0] d);
    sb_q[p].push_back('{cyc + lat, d});
  endtask

  // Counts negedges with ready low, starting at the next negedge, until ready rises.
  task automatic count_busy(input bit sel_b, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (sel_b ? ready_b : ready) break;
      n++;
      if (n > 300) break;
    end
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 64; a++) begin
      tick();
      idle_all();
      for (int b = 0; b < NB; b++) begin
        op(b, 1'b0, a, 64'd0, 64'd0);
        expect_rd(b, 1, 64'd0);
      end
    end
    tick();
    idle_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tab[0]  = '{0, 1'b1, 5,  ONES,                   64'h0000_0000_FFFF_0000, 64'd0};
    tab[1]  = '{0, 1'b0, 5,  64'd0,                  64'd0,                   64'h0000_0000_FFFF_0000};
    tab[2]  = '{0, 1'b1, 5,  64'h1234_5678_9ABC_DEF0, 64'hFF00_0000_0000_00FF, 64'd0};
    tab[3]  = '{0, 1'b0, 5,  64'd0,                  ONES,                    64'h1200_0000_FFFF_00F0};
    tab[4]  = '{2, 1'b1, 3,  64'h5A,                 ONES,                    64'd0};
    tab[5]  = '{3, 1'b1, 63, 64'hDEAD_BEEF_0000_0001, ONES,                    64'd0};
    tab[6]  = '{3, 1'b0, 63, 64'd0,                  64'd0,                   64'hDEAD_BEEF_0000_0001};
    tab[7]  = '{3, 1'b0, 0,  64'd0,                  64'd0,                   64'd0};
    tab[8]  = '{1, 1'b1, 7,  64'hFFFF,               64'd0,                   64'd0};
    tab[9]  = '{1, 1'b0, 7,  64'd0,                  64'd0,                   64'd0};
    tab[10] = '{2, 1'b0, 3,  64'd0,                  64'd0,                   64'h5A};

    idle_all();
    idle_b();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", rdata[63:0], 64'd0);
    check("reset_rvalid", {60'd0, rvalid}, 64'd0);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_ready_noinit", {63'd0, ready_b}, 64'd1);

    // Power-up sweep length, then every location must read zero
    @(posedge clk);
    #1 rst = 1'b0;
    count_busy(1'b0, n);
    check("sweep_len_reset", 64'(n), 64'd64);
    read_all_zero();

    for (int i = 0; i < 11; i++) begin
      tick();
      idle_all();
      op(tab[i].bank, tab[i].w, tab[i].a, tab[i].d, tab[i].m);
      if (!tab[i].w) expect_rd(tab[i].bank, 1, tab[i].exp);
      $display("vector %0d: bank%0d %s addr %0d", i, tab[i].bank, tab[i].w ? "write" : "read", tab[i].a);
    end

    // Write and read in different banks during the same cycle
    tick(); idle_all();
    op(1, 1'b1, 3, 64'hA5, ONES);
    op(2, 1'b0, 3, 64'd0, 64'd0);
    expect_rd(2, 1, 64'h5A);
    tick(); idle_all();
    op(1, 1'b0, 3, 64'd0, 64'd0);
    expect_rd(1, 1, 64'hA5);
    op(0, 1'b1, 5, 64'd0, ONES);
    op(3, 1'b0, 63, 64'd0, 64'd0);
    expect_rd(3, 1, 64'hDEAD_BEEF_0000_0001);
    tick(); idle_all();
    op(3, 1'b0, 0, 64'd0, 64'd0);
    expect_rd(3, 1, 64'd0);
    op(2, 1'b1, 3, 64'h77, ONES);
    tick(); idle_all();
    op(3, 1'b0, 63, 64'd0, 64'd0);
    expect_rd(3, 1, 64'hDEAD_BEEF_0000_0001);
    repeat (3) begin
      tick(); idle_all();
      @(negedge clk);
      check("hold_rdata2", rdata[2*DW +: DW], 64'h5A);
      check("hold_rdata0", rdata[0 +: DW], 64'h1200_0000_FFFF_00F0);
    end

    // Requested sweep: writes ignored, a second init_req does not extend it
    tick(); idle_all();
    for (int b = 0; b < NB; b++) op(b, 1'b1, 62, ONES, ONES);
    tick(); idle_all();
    init_req = 1'b1;
    op(1, 1'b0, 3, 64'd0, 64'd0);
    expect_rd(1, 1, 64'hA5);
    tick(); idle_all();
    n = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      n++;
      if (n > 300) break;
      cs = '1;
      we = 4'($urandom_range(0, 15));
      for (int b = 0; b < NB; b++) begin
        addr[b*AW +: AW]  = AW'($urandom_range(0, 63));
        wdata[b*DW +: DW] = {$urandom, $urandom};
        wmask[b*DW +: DW] = ONES;
      end
      init_req = (n == 20);
    end
    idle_all();
    check("sweep_len_request", 64'(n), 64'd64);
    read_all_zero();

    // Reset in the middle of a sweep
    tick(); idle_all();
    op(0, 1'b1, 7, 64'h77, ONES);
    tick(); idle_all();
    op(0, 1'b0, 7, 64'd0, 64'd0);
    expect_rd(0, 1, 64'h77);
    tick(); idle_all();
    init_req = 1'b1;
    tick(); idle_all();
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset_rdata0", rdata[0 +: DW], 64'd0);
    check("midreset_rvalid", {60'd0, rvalid}, 64'd0);
    check("midreset_ready", {63'd0, ready}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    count_busy(1'b0, n);
    check("sweep_len_after_midreset", 64'(n), 64'd64);

    // DEPTH=48 instance with output register
    tick(); idle_b();
    init_b = 1'b1;
    tick(); idle_b();
    count_busy(1'b1, n);
    check("sweep_len_d48", 64'(n), 64'd48);
    tick(); idle_b();
    op_b(0, 1'b1, 10, 64'hCAFE_F00D_1234_5678, ONES);
    tick(); idle_b();
    op_b(0, 1'b1, 60, ONES, ONES);
    op_b(1, 1'b1, 60, ONES, ONES);
    tick(); idle_b();
    op_b(0, 1'b0, 60, 64'd0, 64'd0);
    expect_rd(4, 2, 64'd0);
    op_b(1, 1'b0, 60, 64'd0, 64'd0);
    expect_rd(5, 2, 64'd0);
    tick(); idle_b();
    op_b(0, 1'b0, 10, 64'd0, 64'd0);
    expect_rd(4, 2, 64'hCAFE_F00D_1234_5678);
    tick(); idle_b();
    op_b(0, 1'b0, 12, 64'd0, 64'd0);
    expect_rd(4, 2, 64'd0);
    tick(); idle_b();
    op_b(0, 1'b0, 28, 64'd0, 64'd0);
    expect_rd(4, 2, 64'd0);
    tick(); idle_b();
    op_b(0, 1'b0, 47, 64'd0, 64'd0);
    expect_rd(4, 2, 64'd0);
    // Read still in the output stage when the sweep begins
    tick(); idle_b();
    op_b(0, 1'b0, 10, 64'd0, 64'd0);
    expect_rd(4, 2, 64'hCAFE_F00D_1234_5678);
    tick(); idle_b();
    init_b = 1'b1;
    tick(); idle_b();
    count_busy(1'b1, n);
    check("sweep_len_d48_inflight", 64'(n), 64'd48);

    repeat (5) tick();
    for (int p = 0; p < 8; p++) check($sformatf("sb_drain_p%0d", p), 64'(sb_q[p].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
